product_selector_multi: RTL and testbench
=========================================

Name: product_selector_multi

Overview:
- Parametrised successor to the fixed 3-product selector in the vending machine datapath. Supports NUM_PRODUCTS selectable products with a runtime-writable price table.
- Adds an internal hold timeout, a vend acknowledge handshake and a user cancel.
- Sits between the keypad decoder (product_sel / product_selector_en) and the coin accumulator / dispenser, which consume product_price, product_out and product_valid.

Parameters:
NUM_PRODUCTS, 7, number of valid product codes (1..NUM_PRODUCTS); code 0 is always invalid.
SEL_W, 3, width of product codes; must satisfy 2**SEL_W > NUM_PRODUCTS.
PRICE_W, 5, width of price entries.
TIMEOUT_CYCLES, 16, maximum number of cycles spent in HOLD before timeout; must be >= 1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cfg_we  in  1  price table write strobe.
cfg_addr  in  SEL_W  product code to write.
cfg_price  in  PRICE_W  price value to write.
product_sel  in  SEL_W  requested product code.
product_selector_en  in  1  request strobe, sampled in IDLE only.
cancel  in  1  user abort, effective in HOLD only.
vend_ack  in  1  dispenser accepted the product, effective in HOLD only.
product_price  out  PRICE_W  latched price of the selected product.
product_out  out  SEL_W  latched product code.
product_valid  out  1  high while a valid selection is held.
product_selector_done  out  1  one-cycle end-of-transaction pulse.
sel_error  out  1  one-cycle pulse for an invalid code or unpriced product.
timeout_flag  out  1  one-cycle pulse when HOLD expires.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, every price table entry 0, FSM in IDLE, timeout counter 0. Reset asserted mid-transaction aborts immediately, with no done pulse.
- Price table write: cfg_we=1 with cfg_addr in 1..NUM_PRODUCTS writes cfg_price at the clock edge. Address 0 or > NUM_PRODUCTS is ignored. Writes are allowed in any state; an already-latched product_price is not changed.
- States: IDLE, LOOKUP, HOLD, DONE. All outputs are registered.
- IDLE: product_selector_en=1 latches product_sel -> LOOKUP. Strobe is ignored in all other states.
- LOOKUP (1 cycle), invalid case: code 0, code > NUM_PRODUCTS, or table entry == 0 -> sel_error=1, then DONE with product_valid=0.
- LOOKUP, valid case: product_out=code, product_price=table entry, product_valid=1, timeout counter loaded with TIMEOUT_CYCLES-1 -> HOLD.
- Latency: en sampled at edge k; product_valid (or sel_error) is high after edge k+1.
- HOLD exit priority, highest first:
  - vend_ack -> DONE.
  - cancel -> clear outputs -> DONE.
  - counter == 0 -> timeout_flag=1, clear outputs -> DONE.
  - otherwise decrement counter.
- HOLD lasts at most TIMEOUT_CYCLES cycles. vend_ack in the final cycle beats the timeout.
- DONE (1 cycle): product_selector_done=1; product_valid, product_out and product_price are cleared -> IDLE.
- A new request is accepted in the cycle after DONE.
- Pulses (done, sel_error, timeout_flag) are exactly 1 cycle wide.

Optional Feature:
- Macro: PRODUCT_SELECTOR_STOCK_EN.
- When defined:
  - Parameters STOCK_W (default 4) and STOCK_INIT (default 3) are added.
  - One stock counter per product, set to STOCK_INIT on reset.
  - vend_ack in HOLD decrements the held product's counter, saturating at 0.
  - In LOOKUP, stock == 0 is treated as invalid: sel_error=1, plus output port sold_out (1 bit) pulses 1 cycle.
  - cfg_we additionally reloads the addressed counter to STOCK_INIT.
- When undefined: no stock logic, no sold_out port; stock never blocks a selection.

Test Plan:
- Write price 12 to code 3, then en with sel=3 -> after 2 edges product_valid=1, product_out=3, product_price=12, busy=1. vend_ack -> done pulse, then outputs 0.
- sel=0 and sel=7 with an unwritten price -> sel_error pulse, done pulse, product_valid never 1.
- Select code 1 (price 5), no ack, TIMEOUT_CYCLES=16 -> timeout_flag after exactly 16 HOLD cycles, done the next cycle, outputs 0.
- vend_ack and cancel asserted together in HOLD -> treated as ack (no clear before DONE). Separately, en asserted during HOLD -> ignored.
- Reset asserted during HOLD -> all outputs 0 immediately, price table cleared, no done pulse.
- With PRODUCT_SELECTOR_STOCK_EN: four vends of code 2 (STOCK_INIT=3) -> fourth gives sel_error and sold_out. A cfg write to code 2 restores vending.

Source files
------------

// File: rtl/product_selector_multi_if.sv
// Keypad/config/dispenser bundle for product_selector_multi.
// sold_out exists only when PRODUCT_SELECTOR_STOCK_EN is defined.
interface product_selector_multi_if #(
    parameter int SEL_W   = 3,
    parameter int PRICE_W = 5
) ();
    logic               cfg_we;
    logic [SEL_W-1:0]   cfg_addr;
    logic [PRICE_W-1:0] cfg_price;
    logic [SEL_W-1:0]   product_sel;
    logic               product_selector_en;
    logic               cancel;
    logic               vend_ack;
    logic [PRICE_W-1:0] product_price;
    logic [SEL_W-1:0]   product_out;
    logic               product_valid;
    logic               product_selector_done;
    logic               sel_error;
    logic               timeout_flag;
    logic               busy;
`ifdef PRODUCT_SELECTOR_STOCK_EN
    logic               sold_out;
`endif

    modport master (
`ifdef PRODUCT_SELECTOR_STOCK_EN
        input  sold_out,
`endif
        output cfg_we, cfg_addr, cfg_price, product_sel, product_selector_en,
               cancel, vend_ack,
        input  product_price, product_out, product_valid, product_selector_done,
               sel_error, timeout_flag, busy
    );

    modport slave (
`ifdef PRODUCT_SELECTOR_STOCK_EN
        output sold_out,
`endif
        input  cfg_we, cfg_addr, cfg_price, product_sel, product_selector_en,
               cancel, vend_ack,
        output product_price, product_out, product_valid, product_selector_done,
               sel_error, timeout_flag, busy
    );
endinterface

// File: rtl/product_selector_multi.sv
// Multi-product selector with writable price table, HOLD timeout, vend ack and cancel.
// Optional per-product stock counters under PRODUCT_SELECTOR_STOCK_EN.
module product_selector_multi #(
    parameter int NUM_PRODUCTS   = 7,
    parameter int SEL_W          = 3,
    parameter int PRICE_W        = 5,
    parameter int TIMEOUT_CYCLES = 16
`ifdef PRODUCT_SELECTOR_STOCK_EN
    ,
    parameter int STOCK_W        = 4,
    parameter int STOCK_INIT     = 3
`endif
) (
    input logic                   clk,
    input logic                   rst_n,
    product_selector_multi_if.slave bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, HOLD, DONE} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   out_q, out_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               to_q, to_d;
    logic               busy_q, busy_d;
    logic               clear;

    // Entry 0 is never written, so code 0 always reads as unpriced.
    logic [PRICE_W-1:0] price_tbl_q [NUM_PRODUCTS+1];
    logic               sel_in_range;
    logic [PRICE_W-1:0] tbl_entry;
    logic               stock_empty;
    logic               sel_ok;

    assign sel_in_range = (sel_q != '0) && (sel_q <= SEL_W'(NUM_PRODUCTS));
    assign tbl_entry    = sel_in_range ? price_tbl_q[sel_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NUM_PRODUCTS; i++) price_tbl_q[i] <= '0;
        end else begin
            for (int i = 1; i <= NUM_PRODUCTS; i++)
                if (bus.cfg_we && bus.cfg_addr == SEL_W'(i)) price_tbl_q[i] <= bus.cfg_price;
        end
    end

`ifdef PRODUCT_SELECTOR_STOCK_EN
    logic [STOCK_W-1:0] stock_q [NUM_PRODUCTS+1];
    logic               sold_q, sold_d;

    assign stock_empty  = sel_in_range && (stock_q[sel_q] == '0);
    assign bus.sold_out = sold_q;

    // A config write restocks the slot and wins over a same-cycle vend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NUM_PRODUCTS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            for (int i = 1; i <= NUM_PRODUCTS; i++) begin
                if (bus.cfg_we && bus.cfg_addr == SEL_W'(i))
                    stock_q[i] <= STOCK_W'(STOCK_INIT);
                else if (state_q == HOLD && bus.vend_ack && sel_q == SEL_W'(i) && stock_q[i] != '0)
                    stock_q[i] <= stock_q[i] - STOCK_W'(1);
            end
        end
    end
`else
    assign stock_empty = 1'b0;
`endif

    assign sel_ok = sel_in_range && (tbl_entry != '0) && !stock_empty;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        out_d   = out_q;
        price_d = price_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        to_d    = 1'b0;
        clear   = 1'b0;
`ifdef PRODUCT_SELECTOR_STOCK_EN
        sold_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.product_selector_en) begin
                    sel_d   = bus.product_sel;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (sel_ok) begin
                    valid_d = 1'b1;
                    out_d   = sel_q;
                    price_d = tbl_entry;
                    cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
                    state_d = HOLD;
                end else begin
                    err_d   = 1'b1;
`ifdef PRODUCT_SELECTOR_STOCK_EN
                    sold_d  = stock_empty;
`endif
                    state_d = DONE;
                end
            end
            HOLD: begin
                // Ack keeps the selection visible through DONE; cancel/timeout clear it now.
                if (bus.vend_ack) begin
                    state_d = DONE;
                end else if (bus.cancel) begin
                    clear   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    to_d    = 1'b1;
                    clear   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                clear   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            valid_d = 1'b0;
            out_d   = '0;
            price_d = '0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            out_q   <= '0;
            price_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PRODUCT_SELECTOR_STOCK_EN
            sold_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            price_q <= price_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
`ifdef PRODUCT_SELECTOR_STOCK_EN
            sold_q  <= sold_d;
`endif
        end
    end

    assign bus.product_out           = out_q;
    assign bus.product_price         = price_q;
    assign bus.product_valid         = valid_q;
    assign bus.product_selector_done = done_q;
    assign bus.sel_error             = err_q;
    assign bus.timeout_flag          = to_q;
    assign bus.busy                  = busy_q;
endmodule

// File: tb/tb_product_selector_multi.sv
// Scoreboard bench for product_selector_multi: the driver predicts timed output events
// from a table/stock model, a negedge monitor pops and compares them.
module tb_product_selector_multi;
    localparam int NUM     = 7;
    localparam int SEL_W   = 3;
    localparam int PRICE_W = 5;
    localparam int T       = 16;
`ifdef PRODUCT_SELECTOR_STOCK_EN
    localparam int STOCK_INIT = 3;
`endif

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    product_selector_multi_if #(.SEL_W(SEL_W), .PRICE_W(PRICE_W)) bus ();

    product_selector_multi #(
        .NUM_PRODUCTS(NUM), .SEL_W(SEL_W), .PRICE_W(PRICE_W), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit valid;
        int out;
        int price;
        bit err;
        bit to;
        bit done;
        bit busy;
        bit sold;
    } ev_t;

    ev_t exp_q[$];
    int  tbl [0:NUM];
    int  stock [0:NUM];

    function automatic void push(int c, bit v, int o, int p, bit e, bit t, bit d, bit b, bit s);
        ev_t x;
        x.cyc = c; x.valid = v; x.out = o; x.price = p;
        x.err = e; x.to = t; x.done = d; x.busy = b; x.sold = s;
        exp_q.push_back(x);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i <= NUM; i++) begin
            tbl[i] = 0;
`ifdef PRODUCT_SELECTOR_STOCK_EN
            stock[i] = STOCK_INIT;
`else
            stock[i] = 1;
`endif
        end
    endfunction

    // Monitor: any pulse or change of product_valid is an event that must match the queue head.
    bit  mon_prev_v;
    ev_t mon_a;
    ev_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev_v = 1'b0;
        end else begin
            mon_a.cyc   = cyc;
            mon_a.valid = bus.product_valid;
            mon_a.out   = int'(bus.product_out);
            mon_a.price = int'(bus.product_price);
            mon_a.err   = bus.sel_error;
            mon_a.to    = bus.timeout_flag;
            mon_a.done  = bus.product_selector_done;
            mon_a.busy  = bus.busy;
`ifdef PRODUCT_SELECTOR_STOCK_EN
            mon_a.sold  = bus.sold_out;
`else
            mon_a.sold  = 1'b0;
`endif
            if (mon_a.err || mon_a.to || mon_a.done || mon_a.sold || (mon_a.valid != mon_prev_v)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d v=%0d o=%0d p=%0d err=%0d to=%0d done=%0d busy=%0d sold=%0d, required no event",
                             mon_a.cyc, mon_a.valid, mon_a.out, mon_a.price, mon_a.err, mon_a.to, mon_a.done, mon_a.busy, mon_a.sold);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_a.cyc != mon_e.cyc || mon_a.valid != mon_e.valid || mon_a.out != mon_e.out ||
                        mon_a.price != mon_e.price || mon_a.err != mon_e.err || mon_a.to != mon_e.to ||
                        mon_a.done != mon_e.done || mon_a.busy != mon_e.busy || mon_a.sold != mon_e.sold) begin
                        errors++;
                        $display("FAIL event got cyc=%0d v=%0d o=%0d p=%0d err=%0d to=%0d done=%0d busy=%0d sold=%0d required cyc=%0d v=%0d o=%0d p=%0d err=%0d to=%0d done=%0d busy=%0d sold=%0d",
                                 mon_a.cyc, mon_a.valid, mon_a.out, mon_a.price, mon_a.err, mon_a.to, mon_a.done, mon_a.busy, mon_a.sold,
                                 mon_e.cyc, mon_e.valid, mon_e.out, mon_e.price, mon_e.err, mon_e.to, mon_e.done, mon_e.busy, mon_e.sold);
                    end
                end
            end
            mon_prev_v = mon_a.valid;
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wcfg(input int addr, input int price);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = SEL_W'(addr);
        bus.cfg_price = PRICE_W'(price);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        if (addr >= 1 && addr <= NUM) begin
            tbl[addr] = price;
`ifdef PRODUCT_SELECTOR_STOCK_EN
            stock[addr] = STOCK_INIT;
`endif
        end
    endtask

    // act: 0 ack, 1 cancel, 2 ack+cancel, 3 let it time out. h = HOLD cycle (1..T) of ack/cancel.
    task automatic txn(input int code, input int act, input int h, input bit extras);
        int k;
        int a;
        int p;
        bit in_rng;
        bit sold;
        bit ok;
        in_rng = (code >= 1 && code <= NUM);
        sold   = in_rng && (stock[code] == 0);
        ok     = in_rng && (tbl[code] != 0) && !sold;
        bus.product_sel         = SEL_W'(code);
        bus.product_selector_en = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        bus.product_selector_en = 1'b0;
        if (!ok) begin
            push(k + 1, 0, 0, 0, 1, 0, 0, 1, sold);
            push(k + 2, 0, 0, 0, 0, 0, 1, 0, 0);
            wait_cyc(k + 2);
            return;
        end
        push(k + 1, 1, code, tbl[code], 0, 0, 0, 1, 0);
        if (extras && (act == 3 || h >= 2)) begin
            // Ignored strobe and a rewrite of the held product's price during HOLD.
            wait_cyc(k + 1);
            p = int'($urandom_range(31, 0));
            bus.product_sel         = SEL_W'($urandom_range(NUM, 1));
            bus.product_selector_en = 1'b1;
            wcfg(code, p);
            bus.product_selector_en = 1'b0;
        end
        if (act == 3) begin
            push(k + 1 + T, 0, 0, 0, 0, 1, 0, 1, 0);
            push(k + 2 + T, 0, 0, 0, 0, 0, 1, 0, 0);
            wait_cyc(k + 2 + T);
        end else begin
            a = k + 1 + h;
            wait_cyc(a - 1);
            bus.vend_ack = (act != 1);
            bus.cancel   = (act != 0);
            if (act == 1) begin
                push(a, 0, 0, 0, 0, 0, 0, 1, 0);
            end else begin
`ifdef PRODUCT_SELECTOR_STOCK_EN
                if (stock[code] > 0) stock[code] = stock[code] - 1;
`endif
            end
            push(a + 1, 0, 0, 0, 0, 0, 1, 0, 0);
            @(negedge clk);
            bus.vend_ack = 1'b0;
            bus.cancel   = 1'b0;
            wait_cyc(a + 1);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.product_valid !== 1'b0 || bus.product_out !== '0 || bus.product_price !== '0 ||
            bus.busy !== 1'b0 || bus.product_selector_done !== 1'b0 || bus.sel_error !== 1'b0 ||
            bus.timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL %s got v=%b o=%0d p=%0d busy=%b done=%b err=%b to=%b, required all zero",
                     name, bus.product_valid, bus.product_out, bus.product_price, bus.busy,
                     bus.product_selector_done, bus.sel_error, bus.timeout_flag);
        end
    endtask

    initial begin
        int k;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_price = '0;
        bus.product_sel = '0; bus.product_selector_en = 1'b0;
        bus.cancel = 1'b0; bus.vend_ack = 1'b0;
        model_reset();
        #1;
        check_idle_outputs("reset_state");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        wcfg(3, 12);
        txn(3, 0, 3, 0);          // basic vend
        txn(0, 0, 1, 0);          // code 0
        txn(7, 0, 1, 0);          // unpriced code
        wcfg(1, 5);
        txn(1, 3, 1, 0);          // full timeout
        txn(1, 0, T, 0);          // ack in last HOLD cycle beats timeout
        txn(3, 2, 4, 1);          // ack+cancel, plus ignored strobe and price rewrite
        txn(3, 1, 2, 0);          // cancel
        wcfg(0, 9);               // ignored address
        txn(0, 0, 1, 0);

`ifdef PRODUCT_SELECTOR_STOCK_EN
        wcfg(2, 9);
        for (int i = 0; i < 4; i++) txn(2, 0, 1, 0);
        wcfg(2, 9);
        txn(2, 0, 2, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1, 0) == 1)
                wcfg(int'($urandom_range(NUM, 0)), int'($urandom_range(31, 0)));
            txn(int'($urandom_range(NUM, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(T, 1)), bit'($urandom_range(1, 0)));
        end

        // Reset in the middle of HOLD.
        wcfg(3, 12);
        bus.product_sel = SEL_W'(3);
        bus.product_selector_en = 1'b1;
        k = cyc + 1;
        push(k + 1, 1, 3, 12, 0, 0, 0, 1, 0);
        @(negedge clk);
        bus.product_selector_en = 1'b0;
        wait_cyc(k + 3);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_in_hold");
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        txn(3, 0, 1, 0);          // table was cleared, so this must be rejected

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
